// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, divide-by-zero fill.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  // Divide by zero sets every quotient bit; the remainder is the untouched dividend.
  localparam logic DIV0_QUOT_BIT = 1'b1;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step on the {upper,lower} accumulator: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div,
  input  logic [XLEN-1:0]     opnd,
  input  logic [2*XLEN-1:0]   acc_in,
  output logic [2*XLEN-1:0]   acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Multiply shifts right with carry; divide shifts left and subtracts when the trial fits.
  always_comb begin
    sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, opnd};
    trial = acc_in[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, opnd};
    acc_out = acc_in;
    if (is_div) begin
      if (trial >= {1'b0, opnd}) begin
        acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Optional MULDIV_EARLY_EXIT_EN: zero multiply operand or zero divisor jumps straight to FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int K     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  state_t state, state_next;

  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              is_div, neg_q, neg_r, b_zero;

  logic              op_div, op_signed, sa, sb, accept, idle_cmd, zero_skip;
  logic [XLEN-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [2*XLEN-1:0] chain [UNROLL+1];

  assign op_div    = is_div_op(op);
  assign op_signed = is_signed_op(op);
  assign sa        = op_signed & src_a[XLEN-1];
  assign sb        = op_signed & src_b[XLEN-1];
  assign mag_a     = sa ? -src_a : src_a;
  assign mag_b     = sb ? -src_b : src_b;
  assign idle_cmd  = (state == ST_IDLE) && start && !abort;
  assign accept    = idle_cmd && is_muldiv_op(op);

`ifdef MULDIV_EARLY_EXIT_EN
  assign zero_skip = op_div ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`else
  assign zero_skip = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  assign chain[0] = acc;
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (is_div),
      .opnd    (opnd),
      .acc_in  (chain[g]),
      .acc_out (chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = zero_skip ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (abort)              state_next = ST_IDLE;
        else if (count == CNT_W'(1)) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sign correction: product negated over the full width, quotient/remainder separately.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (is_div) begin
      res_lo = b_zero ? {XLEN{DIV0_QUOT_BIT}}
                      : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      res_hi = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end else begin
      {res_hi, res_lo} = neg_q ? -acc : acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            count  <= K_CNT;
            is_div <= op_div;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (src_b == '0);
            if (op_div) begin
              opnd <= mag_b;
              acc  <= {{XLEN{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{XLEN{1'b0}}, mag_b};
            end
`ifdef MULDIV_EARLY_EXIT_EN
            if (zero_skip) acc <= op_div ? {mag_a, {XLEN{1'b1}}} : '0;
`endif
          end else if (idle_cmd && (op == OP_MTHI)) begin
            hi <= src_a;
          end else if (idle_cmd && (op == OP_MTLO)) begin
            lo <= src_a;
          end
        end
        ST_CALC: begin
          if (!abort) begin
            acc   <= chain[UNROLL];
            count <= count - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!abort) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/latency queued at issue, checked on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst;
  logic        start, abort;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start4;
  logic [2:0]  op4;
  logic [31:0] src_a4, src_b4;
  logic        busy4, done4;
  logic [31:0] hi4, lo4;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          issue;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cycle_cnt = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut_u4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .src_a(src_a4), .src_b(src_b4),
    .abort(1'b0), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Independent reference: SV arithmetic plus the architectural special cases.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  begin p = longint'(sa) * longint'(sb); return p; end
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    if ((o == OP_DIV || o == OP_DIVU) ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) return 1;
`endif
    if (o > OP_DIVU || a === 32'hx) return 0;
    return 33;
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit expect_done, input logic [31:0] ehi, input logic [31:0] elo,
                               input string tag);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    if (expect_done) begin
      e.hi = ehi; e.lo = elo; e.issue = cycle_cnt; e.lat = exp_lat(o, a, b); e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checkOutput("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    applyStimulus(o, a, b, 1'b1, ehi, elo, tag);
    wait_idle();
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.tag, "_hi"}, 64'(hi), 64'(mon_e.hi));
        checkOutput({mon_e.tag, "_lo"}, 64'(lo), 64'(mon_e.lo));
        checkOutput({mon_e.tag, "_lat"}, 64'(cycle_cnt - mon_e.issue), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] m;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          lat4;

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    start4 = 1'b0; op4 = 3'd0; src_a4 = '0; src_b4 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;

    run_op(OP_MULT,  32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(OP_DIVU,  32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0");
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(OP_MULT,  32'd0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mult_zero");

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) ra = 32'h8000_0000;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], $sformatf("rand%0d_op%0d", i, ro));
    end

    // Four steps per cycle: K=8, so done arrives nine edges after the start edge.
    @(negedge clk);
    start4 = 1'b1; op4 = OP_MULTU; src_a4 = 32'hFFFF_FFFF; src_b4 = 32'hFFFF_FFFF;
    @(negedge clk);
    start4 = 1'b0;
    lat4 = 0;
    while (!done4 && lat4 < 50) begin
      @(negedge clk);
      lat4++;
    end
    checkOutput("u4_lat", 64'(lat4), 64'd9);
    checkOutput("u4_hi", 64'(hi4), 64'h0000_0000_FFFF_FFFE);
    checkOutput("u4_lo", 64'(lo4), 64'h0000_0000_0000_0001);

    applyStimulus(OP_MTLO, 32'h1234, 32'd0, 1'b0, '0, '0, "mtlo");
    checkOutput("mtlo_lo", 64'(lo), 64'h1234);
    checkOutput("mtlo_busy", 64'(busy), 64'd0);
    checkOutput("mtlo_done", 64'(done), 64'd0);
    applyStimulus(OP_MTHI, 32'hABCD, 32'd0, 1'b0, '0, '0, "mthi");
    checkOutput("mthi_hi", 64'(hi), 64'hABCD);
    checkOutput("mthi_lo_kept", 64'(lo), 64'h1234);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    exp_hi = 32'hABCD; exp_lo = 32'h1234;

    applyStimulus(3'd6, 32'h5555, 32'h1, 1'b0, '0, '0, "op6");
    checkOutput("op6_busy", 64'(busy), 64'd0);
    checkOutput("op6_hi", 64'(hi), 64'(exp_hi));

    // Abort beats start in IDLE.
    @(negedge clk);
    abort = 1'b1; start = 1'b1; op = OP_MTLO; src_a = 32'd77;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_start_lo", 64'(lo), 64'(exp_lo));
    checkOutput("abort_start_busy", 64'(busy), 64'd0);

    // MTHI while busy is dropped; HI/LO hold through CALC.
    applyStimulus(OP_MULT, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, "mult_3_5");
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mthi_busy_ignored", 64'(hi), 64'(exp_hi));
    checkOutput("calc_lo_held", 64'(lo), 64'(exp_lo));
    wait_idle();
    exp_hi = 32'd0; exp_lo = 32'd15;

    // Ignored DIV at cycle 5, abort at cycle 10.
    applyStimulus(OP_MULT, 32'd9, 32'd9, 1'b0, '0, '0, "mult_abort");
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'(exp_hi));
    checkOutput("abort_lo", 64'(lo), 64'(exp_lo));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 10 == 0) checkOutput("abort_no_done", 64'(done), 64'd0);
    end

    // Restart then reset mid-op.
    applyStimulus(OP_MULT, 32'd11, 32'd13, 1'b0, '0, '0, "mult_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midop_reset_hi", 64'(hi), 64'd0);
    checkOutput("midop_reset_lo", 64'(lo), 64'd0);
    checkOutput("midop_reset_busy", 64'(busy), 64'd0);
    checkOutput("midop_reset_done", 64'(done), 64'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("post_reset_lo", 64'(lo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
